// File: rtl/sync_decimal_add_counter.sv
// ----------------------------------------------------------------------------
// sync_decimal_add_counter
//
// Two-digit BCD up-counter (00..TC) with synchronous parallel load, master
// reset, carry-in / carry-out for cascading, and a sticky error flag that
// records rejected loads.
//
// Parameters
//   TC       BCD terminal count (tens [7:4], units [3:0]); counter wraps to 00
//            on the step taken while q == TC.
//   RST_VAL  BCD value taken by q on master reset and at power-up.
//
// Ports
//   clk   in   1  clock, rising edge active
//   mr    in   1  master reset, synchronous, active-high (highest priority)
//   en    in   1  count enable
//   ci    in   1  carry-in; tie high when standalone
//   ld    in   1  synchronous parallel load strobe (beats counting)
//   d     in   8  BCD load value
//   q     out  8  registered BCD count
//   co    out  1  combinational carry-out, high on the step that wraps
//   err   out  1  registered sticky flag, set by a rejected load
// ----------------------------------------------------------------------------
module sync_decimal_add_counter #(
   parameter logic [7:0] TC      = 8'h99,
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       mr,
   input  logic       en,
   input  logic       ci,
   input  logic       ld,
   input  logic [7:0] d,
   output logic [7:0] q,
   output logic       co,
   output logic       err
);

   // Declaration initialisers give the power-up state without an mr pulse.
   logic [7:0] r_q   = RST_VAL;
   logic       r_err = 1'b0;

   logic       w_at_tc;
   logic       w_step;
   logic       w_d_ok;

   // Increment a valid, non-terminal BCD value by one.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Valid BCD codes order the same as binary, so compare the raw codes.
   assign w_at_tc = (r_q == TC);
   assign w_d_ok  = (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9) && (d <= TC);
   assign w_step  = en & ci;

   // Gated by mr and ld so a downstream stage only advances on a real wrap.
   assign co = w_step & w_at_tc & ~mr & ~ld;

   always_ff @(posedge clk) begin
      if (mr) begin
         r_q   <= RST_VAL;
         r_err <= 1'b0;
      end else if (ld) begin
         if (w_d_ok) begin
            r_q   <= d;
            r_err <= 1'b0;
         end else begin
            r_err <= 1'b1;
         end
      end else if (w_step) begin
         r_q <= w_at_tc ? 8'h00 : bcd_inc(r_q);
      end
   end

   assign q   = r_q;
   assign err = r_err;

endmodule

// File: tb/tb_sync_decimal_add_counter.sv
// ----------------------------------------------------------------------------
// Testbench for sync_decimal_add_counter.
// Two single instances (default TC=99, and TC=59 / RST_VAL=12) share one
// stimulus stream; a two-stage cascade is exercised separately.
// ----------------------------------------------------------------------------
module tb_sync_decimal_add_counter;

   typedef struct packed {
      logic [7:0] q;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       mr = 1'b0, en = 1'b0, ci = 1'b0, ld = 1'b0;
   logic [7:0] d = 8'h00;

   logic [7:0] q_a, q_b;
   logic       co_a, co_b, err_a, err_b;

   logic       c_mr = 1'b0, c_en = 1'b0;
   logic [7:0] q_lo, q_hi;
   logic       co_lo, co_hi, err_lo, err_hi;

   int n_checks = 0;
   int n_errors = 0;

   exp_t       st_a, st_b;
   exp_t       sb_a[$], sb_b[$];
   logic [15:0] sb_c[$];

   always #5 clk = ~clk;

   sync_decimal_add_counter #(.TC(8'h99), .RST_VAL(8'h00)) u_a (
      .clk(clk), .mr(mr), .en(en), .ci(ci), .ld(ld), .d(d),
      .q(q_a), .co(co_a), .err(err_a));

   sync_decimal_add_counter #(.TC(8'h59), .RST_VAL(8'h12)) u_b (
      .clk(clk), .mr(mr), .en(en), .ci(ci), .ld(ld), .d(d),
      .q(q_b), .co(co_b), .err(err_b));

   sync_decimal_add_counter u_lo (
      .clk(clk), .mr(c_mr), .en(c_en), .ci(1'b1), .ld(1'b0), .d(8'h00),
      .q(q_lo), .co(co_lo), .err(err_lo));

   sync_decimal_add_counter u_hi (
      .clk(clk), .mr(c_mr), .en(c_en), .ci(co_lo), .ld(1'b0), .d(8'h00),
      .q(q_hi), .co(co_hi), .err(err_hi));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model works on decimal integers rather than nibbles.
   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

   function automatic exp_t model_next(input exp_t cur, input logic m, input logic l,
                                       input logic e, input logic c, input logic [7:0] dd,
                                       input logic [7:0] tc, input logic [7:0] rstv);
      exp_t n;
      n = cur;
      if (m) begin
         n.q = rstv; n.err = 1'b0;
      end else if (l) begin
         if (dd[7:4] < 4'd10 && dd[3:0] < 4'd10 && bcd2int(dd) <= bcd2int(tc)) begin
            n.q = dd; n.err = 1'b0;
         end else begin
            n.err = 1'b1;
         end
      end else if (e && c) begin
         n.q = (bcd2int(cur.q) == bcd2int(tc)) ? 8'h00 : int2bcd(bcd2int(cur.q) + 1);
      end
      return n;
   endfunction

   // One clock of stimulus on the shared inputs of u_a and u_b.
   task automatic step(input logic s_mr, input logic s_ld, input logic s_en,
                       input logic s_ci, input logic [7:0] s_d);
      exp_t ea, eb;
      logic exp_co_a, exp_co_b;
      @(negedge clk);
      mr = s_mr; ld = s_ld; en = s_en; ci = s_ci; d = s_d;
      #1;
      exp_co_a = s_en & s_ci & ~s_mr & ~s_ld & (st_a.q == 8'h99);
      exp_co_b = s_en & s_ci & ~s_mr & ~s_ld & (st_b.q == 8'h59);
      chk("co_a", {15'd0, co_a}, {15'd0, exp_co_a});
      chk("co_b", {15'd0, co_b}, {15'd0, exp_co_b});
      sb_a.push_back(model_next(st_a, s_mr, s_ld, s_en, s_ci, s_d, 8'h99, 8'h00));
      sb_b.push_back(model_next(st_b, s_mr, s_ld, s_en, s_ci, s_d, 8'h59, 8'h12));
      @(posedge clk);
      #1;
      ea = sb_a.pop_front();
      eb = sb_b.pop_front();
      chk("q_a",   {8'd0, q_a},    {8'd0, ea.q});
      chk("err_a", {15'd0, err_a}, {15'd0, ea.err});
      chk("q_b",   {8'd0, q_b},    {8'd0, eb.q});
      chk("err_b", {15'd0, err_b}, {15'd0, eb.err});
      st_a = ea;
      st_b = eb;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int lo_n, hi_n;
      logic [15:0] ec;
      logic r_ld, r_mr;

      st_a = '{q: 8'h00, err: 1'b0};
      st_b = '{q: 8'h12, err: 1'b0};

      // Power-up state before any edge
      #1;
      chk("pwr_q_a",   {8'd0, q_a},    16'h0000);
      chk("pwr_err_a", {15'd0, err_a}, 16'h0000);
      chk("pwr_q_b",   {8'd0, q_b},    16'h0012);

      step(1, 0, 0, 0, 8'h00);

      // Full count sweep: A walks 00..99,00; B wraps at 59
      for (int i = 0; i < 100; i++) step(0, 0, 1, 1, 8'h00);
      chk("sweep_a_end", {8'd0, q_a}, 16'h0000);

      // Load 58 and count through the TC=59 wrap on B
      step(0, 1, 0, 0, 8'h58);
      step(0, 0, 1, 1, 8'h00);
      step(0, 0, 1, 1, 8'h00);
      step(0, 1, 0, 0, 8'h58);
      step(0, 0, 1, 1, 8'h00);
      step(0, 0, 0, 1, 8'h00);   // en=0 at q=59: hold, co=0
      step(0, 0, 0, 1, 8'h00);

      // Load validation and sticky error
      step(0, 1, 1, 1, 8'h3A);
      step(0, 0, 1, 1, 8'h00);   // counting leaves err set
      step(0, 1, 0, 0, 8'h42);
      step(0, 1, 0, 0, 8'h60);   // valid for A, exceeds TC for B
      step(0, 0, 1, 1, 8'h00);
      step(0, 1, 0, 0, 8'hA5);

      // Reset dominates load and count while A sits at TC
      step(0, 1, 0, 0, 8'h99);
      step(1, 1, 1, 1, 8'h25);

      // Load ignores en/ci; ci=0 blocks counting
      step(0, 1, 0, 0, 8'h07);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00);

      // Mixed traffic
      for (int i = 0; i < 60; i++) begin
         r_mr = ($urandom_range(0, 19) == 0);
         r_ld = ($urandom_range(0, 5) == 0);
         step(r_mr, r_ld, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
              8'($urandom_range(0, 255)));
      end

      // Cascade: upper advances only on the lower wrap
      @(negedge clk);
      mr = 1'b0; ld = 1'b0; en = 1'b0; ci = 1'b0;
      c_mr = 1'b1;
      @(posedge clk);
      #1;
      chk("casc_rst", {q_hi, q_lo}, 16'h0000);
      lo_n = 0; hi_n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         c_mr = 1'b0; c_en = 1'b1;
         #1;
         chk("casc_co_lo", {15'd0, co_lo}, {15'd0, (lo_n == 99)});
         if (lo_n == 99) begin
            lo_n = 0;
            hi_n = (hi_n == 99) ? 0 : hi_n + 1;
         end else begin
            lo_n = lo_n + 1;
         end
         sb_c.push_back({int2bcd(hi_n), int2bcd(lo_n)});
         @(posedge clk);
         #1;
         ec = sb_c.pop_front();
         chk("casc_q", {q_hi, q_lo}, ec);
      end
      chk("casc_final", {q_hi, q_lo}, 16'h0100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sync_decimal_add_counter.md
SYNC_DECIMAL_ADD_COUNTER -- requirements
Module: sync_decimal_add_counter

Interface
REQ-001 The block SHALL expose parameter TC, default 8'h99, BCD terminal count (tens in [7:4], units in [3:0]); both nibbles 0-9, value nonzero.
REQ-002 The block SHALL expose parameter RST_VAL, default 8'h00, BCD value of q after reset; both nibbles 0-9, RST_VAL <= TC.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 mr  input  1  master reset; synchronous, active-high.
REQ-005 en  input  1  count enable.
REQ-006 ci  input  1  carry-in for cascading; tie high when standalone.
REQ-007 ld  input  1  synchronous parallel load strobe.
REQ-008 d  input  8  BCD load value, tens d[7:4], units d[3:0].
REQ-009 q  output  8  BCD count, tens q[7:4], units q[3:0]; registered.
REQ-010 co  output  1  carry-out (terminal count reached while counting); combinational.
REQ-011 err  output  1  sticky flag for rejected load; registered.

Function
REQ-012 Priority per rising edge SHALL be mr > ld > count > hold.
REQ-013 Count step SHALL occur when mr=0, ld=0, en=1, ci=1; otherwise q holds.
REQ-014 On count step with q != TC: units < 9 -> units+1, tens unchanged; units = 9 -> units 0, tens+1.
REQ-015 On count step with q == TC: q SHALL wrap to 8'h00 in the same edge.
REQ-016 Tens nibble SHALL never exceed 9 and units nibble SHALL never exceed 9 in any reachable state.
REQ-017 co SHALL equal en & ci & (q == TC) & ~mr & ~ld, zero latency, so a downstream stage with ci=co advances on the same edge as the wrap.
REQ-018 ld with d a valid BCD value (both nibbles <= 9) and d <= TC SHALL set q=d on that edge and clear err.
REQ-019 ld with invalid d (any nibble > 9, or d > TC) SHALL leave q unchanged and set err=1 on that edge.
REQ-020 err SHALL remain 1 until mr or a valid load; counting does not affect err.
REQ-021 ld SHALL take effect regardless of en and ci.
REQ-022 Count latency: q changes one edge after en&ci sampled high; no pipelining.
REQ-023 BCD comparisons (d <= TC, q == TC) SHALL be done on the 8-bit BCD codes directly (valid BCD ordering equals binary ordering).

Reset
REQ-024 mr=1 at a rising edge SHALL set q=RST_VAL and err=0, overriding ld, en and ci, including mid-count and in the TC cycle.
REQ-025 co SHALL be 0 while mr=1.
REQ-026 Registers SHALL power up to the reset values (q=RST_VAL, err=0) without an initial mr pulse.

Verification
REQ-027 Default parameters, mr pulse then en=ci=1 for 100 edges -> q steps 00,01..09,10..99,00; co=1 only during the q=99 cycle.
REQ-028 TC=8'h59: load 8'h58, count 2 edges -> q=59 then 00; co high exactly while q=59 with en=ci=1; en=0 at q=59 -> q holds, co=0.
REQ-029 Load d=8'h3A -> q unchanged, err=1; then load d=8'h42 -> q=42, err=0; with TC=8'h59, load 8'h60 -> q unchanged, err=1.
REQ-030 Two instances cascaded (ci of upper = co of lower, both en=1): after 100 lower-stage edges upper q=01, lower q=00; upper never advances at other edges.
REQ-031 mr=1 with ld=1, d=8'h25, en=ci=1 at q=TC -> q=RST_VAL, err=0, co=0 during that cycle.
REQ-032 ld=1, d=8'h07 with en=0, ci=0 -> q=07 next edge; ld=0, ci=0, en=1 for 5 edges -> q stays 07.
